// File: rtl/zoom_col_repeat_if.sv
// Pixel stream bundle for zoom_col_repeat.
// Upstream side: us_vld / us_rd_data in, zoom_rdy out.
// Downstream side: ds_vld / ds_rd_data / ds_rep_last out, ds_rdy in.
// Handshake: a word moves on any cycle where vld and rdy are both high; the
// sender holds vld and data stable until that cycle and never drops vld early.
// The slave modport is the replicator; the master modport is its environment.
interface zoom_col_repeat_if #(
  parameter int DATA_W = 32
) ();
  logic              us_vld;
  logic              zoom_rdy;
  logic [DATA_W-1:0] us_rd_data;
  logic              ds_vld;
  logic              ds_rdy;
  logic [DATA_W-1:0] ds_rd_data;
  logic              ds_rep_last;

  modport slave (
    input  us_vld, us_rd_data, ds_rdy,
    output zoom_rdy, ds_vld, ds_rd_data, ds_rep_last
  );

  modport master (
    output us_vld, us_rd_data, ds_rdy,
    input  zoom_rdy, ds_vld, ds_rd_data, ds_rep_last
  );
endinterface

// File: rtl/zoom_col_repeat.sv
// zoom_col_repeat: column replicator for digital zoom on packed YCbCr 4:2:2
// words ({cr,y1,cb,y0}; bits above 31 ride along untouched).
// Each accepted word is re-emitted N = 2/4/8 times. When en & en_zoom is low
// the block is a combinational pass-through and any held word is dropped.
// Ports:
//   clk, rst        single clock, synchronous active-high reset
//   en, en_zoom     replicate mode = en & en_zoom
//   sel_zoom_mode   00 = 2x, 01 = 4x, 10 = 8x, 11 = 2x
//   bus (slave)     upstream us_vld/us_rd_data/zoom_rdy and downstream
//                   ds_vld/ds_rdy/ds_rd_data/ds_rep_last
module zoom_col_repeat #(
  parameter int DATA_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 en_zoom,
  input  logic [1:0]           sel_zoom_mode,
  zoom_col_repeat_if.slave     bus
);

  logic              hold_vld_q, hold_vld_d;
  logic [DATA_W-1:0] hold_data_q, hold_data_d;
  logic [2:0]        rep_cnt_q, rep_cnt_d;
  logic [2:0]        rep_max_q, rep_max_d;

  logic       rep_mode;
  logic [2:0] rep_max;
  logic       rep_last;
  logic       rep_rdy;
  logic       load;
  logic       ds_xfer;

  assign rep_mode = en & en_zoom;

  // Copy index of the final copy; 2'b11 falls back to 2x.
  always_comb begin
    rep_max = 3'd1;
    case (sel_zoom_mode)
      2'b01:   rep_max = 3'd3;
      2'b10:   rep_max = 3'd7;
      default: rep_max = 3'd1;
    endcase
  end

  assign rep_last = hold_vld_q & (rep_cnt_q == rep_max_q);
  // Accepting on the last copy's transfer lets the next word follow with no gap.
  assign rep_rdy  = ~hold_vld_q | (bus.ds_rdy & rep_last);
  assign load     = bus.us_vld & rep_rdy;
  assign ds_xfer  = hold_vld_q & bus.ds_rdy;

  always_comb begin
    if (rep_mode) begin
      bus.ds_vld      = hold_vld_q;
      bus.ds_rd_data  = hold_data_q;
      bus.ds_rep_last = rep_last;
      bus.zoom_rdy    = rep_rdy;
    end else begin
      bus.ds_vld      = bus.us_vld;
      bus.ds_rd_data  = bus.us_rd_data;
      bus.ds_rep_last = 1'b1;
      bus.zoom_rdy    = bus.ds_rdy;
    end
  end

  always_comb begin
    hold_vld_d  = hold_vld_q;
    hold_data_d = hold_data_q;
    rep_cnt_d   = rep_cnt_q;
    rep_max_d   = rep_max_q;
    if (!rep_mode) begin
      // Re-entering replicate mode must start empty at copy 0 so the
      // downstream column counter stays phase-aligned.
      hold_vld_d = 1'b0;
      rep_cnt_d  = 3'd0;
    end else begin
      if (ds_xfer) begin
        if (rep_last) begin
          hold_vld_d = 1'b0;
          rep_cnt_d  = 3'd0;
        end else begin
          rep_cnt_d = rep_cnt_q + 3'd1;
        end
      end
      // A load in the same cycle as the last copy overrides the clear above.
      if (load) begin
        hold_vld_d  = 1'b1;
        hold_data_d = bus.us_rd_data;
        rep_cnt_d   = 3'd0;
        rep_max_d   = rep_max;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_vld_q  <= 1'b0;
      hold_data_q <= '0;
      rep_cnt_q   <= 3'd0;
      rep_max_q   <= 3'd1;
    end else begin
      hold_vld_q  <= hold_vld_d;
      hold_data_q <= hold_data_d;
      rep_cnt_q   <= rep_cnt_d;
      rep_max_q   <= rep_max_d;
    end
  end

endmodule

// File: tb/tb_zoom_col_repeat.sv
module tb_zoom_col_repeat;
  localparam int W = 33;  // {last, data}

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       en_zoom = 1'b0;
  logic [1:0] sel_zoom_mode = 2'b00;

  zoom_col_repeat_if #(.DATA_W(32)) bus ();

  zoom_col_repeat #(.DATA_W(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .en_zoom       (en_zoom),
    .sel_zoom_mode (sel_zoom_mode),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad = 0;

  // One clock: drive inputs, observe at negedge, push expected copies for an
  // accepted word, then return just after the next posedge.
  task automatic cycle(input logic v, input logic [31:0] d, input logic r,
                       output logic xf, output logic ac, output logic [31:0] dt,
                       output logic ls, output logic rd, output logic vl);
    int n;
    bus.us_vld = v;
    bus.us_rd_data = d;
    bus.ds_rdy = r;
    @(negedge clk);
    vl = bus.ds_vld;
    dt = bus.ds_rd_data;
    ls = bus.ds_rep_last;
    rd = bus.zoom_rdy;
    xf = vl & r;
    ac = v & rd;
    if (ac) begin
      if (en & en_zoom) n = (sel_zoom_mode == 2'b01) ? 4 : (sel_zoom_mode == 2'b10) ? 8 : 2;
      else n = 1;
      for (int i = 0; i < n; i++) exp_q.push_back({(i == n - 1), d});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; en_zoom = 1'b1; sel_zoom_mode = 2'b00;
    bus.us_vld = 1'b0; bus.us_rd_data = 32'hDEAD_BEEF; bus.ds_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    total++; if (bus.ds_vld !== 1'b0) begin bad++; $display("FAIL rst_ds_vld got=%b want=0", bus.ds_vld); end
    total++; if (bus.zoom_rdy !== 1'b1) begin bad++; $display("FAIL rst_zoom_rdy got=%b want=1", bus.zoom_rdy); end
    total++; if (bus.ds_rep_last !== 1'b0) begin bad++; $display("FAIL rst_rep_last got=%b want=0", bus.ds_rep_last); end
    total++; if (bus.ds_rd_data !== 32'h0) begin bad++; $display("FAIL rst_data got=%h want=0", bus.ds_rd_data); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_2x_back_to_back();
    logic [31:0] words [2];
    logic xf, ac, ls, rd, vl; logic [31:0] dt; logic [W-1:0] e;
    int idx = 0, nx = 0;
    words[0] = 32'hA1A2_A3A4; words[1] = 32'hB1B2_B3B4;
    en = 1'b1; en_zoom = 1'b1; sel_zoom_mode = 2'b00;
    for (int c = 0; c < 10; c++) begin
      cycle(idx < 2, words[idx < 2 ? idx : 0], 1'b1, xf, ac, dt, ls, rd, vl);
      if (ac) idx++;
      if (c == 1) begin
        total++; if (rd !== 1'b0) begin bad++; $display("FAIL t1_rdy_copy0 got=%b want=0", rd); end
      end
      if (c >= 1 && c <= 4) begin
        total++; if (vl !== 1'b1) begin bad++; $display("FAIL t1_continuous c=%0d ds_vld got=%b want=1", c, vl); end
      end
      if (xf) begin
        nx++; total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL t1_extra got=%h want=none", dt); end
        else begin
          e = exp_q.pop_front();
          if ({ls, dt} !== e) begin bad++; $display("FAIL t1_word got=%b/%h want=%b/%h", ls, dt, e[32], e[31:0]); end
        end
      end
    end
    total++; if (nx != 4) begin bad++; $display("FAIL t1_count got=%0d want=4", nx); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL t1_leftover got=%0d want=0", exp_q.size()); end
  endtask

  task automatic test_8x_single();
    logic xf, ac, ls, rd, vl; logic [31:0] dt; logic [W-1:0] e;
    int idx = 0, nx = 0;
    sel_zoom_mode = 2'b10;
    for (int c = 0; c < 12; c++) begin
      cycle(idx < 1, 32'h1122_3344, 1'b1, xf, ac, dt, ls, rd, vl);
      if (ac) idx++;
      if (c >= 1 && c <= 7) begin
        total++; if (rd !== 1'b0) begin bad++; $display("FAIL t2_rdy c=%0d got=%b want=0", c, rd); end
      end
      if (xf) begin
        nx++; total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL t2_extra got=%h want=none", dt); end
        else begin
          e = exp_q.pop_front();
          if ({ls, dt} !== e) begin bad++; $display("FAIL t2_word got=%b/%h want=%b/%h", ls, dt, e[32], e[31:0]); end
        end
      end
    end
    total++; if (nx != 8) begin bad++; $display("FAIL t2_count got=%0d want=8", nx); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL t2_leftover got=%0d want=0", exp_q.size()); end
  endtask

  task automatic test_stall();
    logic xf, ac, ls, rd, vl; logic [31:0] dt; logic [W-1:0] e;
    int idx = 0, nx = 0;
    sel_zoom_mode = 2'b01;
    for (int c = 0; c < 14; c++) begin
      cycle(idx < 1, 32'hC0FF_EE01, !(c >= 3 && c <= 7), xf, ac, dt, ls, rd, vl);
      if (ac) idx++;
      if (c >= 3 && c <= 7) begin
        total++;
        if (vl !== 1'b1 || dt !== 32'hC0FF_EE01 || ls !== 1'b0) begin
          bad++; $display("FAIL t3_frozen c=%0d got vld=%b data=%h last=%b want 1/c0ffee01/0", c, vl, dt, ls);
        end
      end
      if (xf) begin
        nx++; total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL t3_extra got=%h want=none", dt); end
        else begin
          e = exp_q.pop_front();
          if ({ls, dt} !== e) begin bad++; $display("FAIL t3_word got=%b/%h want=%b/%h", ls, dt, e[32], e[31:0]); end
        end
      end
    end
    total++; if (nx != 4) begin bad++; $display("FAIL t3_count got=%0d want=4", nx); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL t3_leftover got=%0d want=0", exp_q.size()); end
  endtask

  task automatic test_mode_change();
    logic [31:0] words [2];
    logic xf, ac, ls, rd, vl; logic [31:0] dt; logic [W-1:0] e;
    int idx = 0, nx = 0;
    words[0] = 32'h4444_0001; words[1] = 32'h8888_0002;
    for (int c = 0; c < 20; c++) begin
      sel_zoom_mode = (c >= 2) ? 2'b10 : 2'b01;
      cycle(idx < 2, words[idx < 2 ? idx : 0], 1'b1, xf, ac, dt, ls, rd, vl);
      if (ac) idx++;
      if (xf) begin
        nx++; total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL t4_extra got=%h want=none", dt); end
        else begin
          e = exp_q.pop_front();
          if ({ls, dt} !== e) begin bad++; $display("FAIL t4_word got=%b/%h want=%b/%h", ls, dt, e[32], e[31:0]); end
        end
      end
    end
    total++; if (nx != 12) begin bad++; $display("FAIL t4_count got=%0d want=12", nx); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL t4_leftover got=%0d want=0", exp_q.size()); end
  endtask

  task automatic test_bypass();
    logic xf, ac, ls, rd, vl; logic [31:0] dt; logic [W-1:0] e;
    logic v = 1'b0, r;
    logic [31:0] d = 32'h0;
    int n_in = 0, n_out = 0;
    en_zoom = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (!v && $urandom_range(0, 2) != 0) begin v = 1'b1; d = $urandom; end
      r = ($urandom_range(0, 3) != 0);
      cycle(v, d, r, xf, ac, dt, ls, rd, vl);
      total++;
      if (vl !== v || ls !== 1'b1 || rd !== r || (v && dt !== d)) begin
        bad++; $display("FAIL t5_mirror c=%0d got vld=%b rdy=%b last=%b data=%h want %b/%b/1/%h", c, vl, rd, ls, dt, v, r, d);
      end
      if (ac) begin n_in++; v = 1'b0; end
      if (xf) begin
        n_out++; total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL t5_extra got=%h want=none", dt); end
        else begin
          e = exp_q.pop_front();
          if ({ls, dt} !== e) begin bad++; $display("FAIL t5_word got=%b/%h want=%b/%h", ls, dt, e[32], e[31:0]); end
        end
      end
    end
    total++; if (n_in != n_out) begin bad++; $display("FAIL t5_counts in=%0d out=%0d", n_in, n_out); end
    // Finish any word still offered so the upstream never retracts it.
    for (int c = 0; c < 5 && v; c++) begin
      cycle(v, d, 1'b1, xf, ac, dt, ls, rd, vl);
      if (ac) v = 1'b0;
      if (xf) begin
        total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL t5_extra got=%h want=none", dt); end
        else begin
          e = exp_q.pop_front();
          if ({ls, dt} !== e) begin bad++; $display("FAIL t5_word got=%b/%h want=%b/%h", ls, dt, e[32], e[31:0]); end
        end
      end
    end
    total++; if (exp_q.size() != 0 || v) begin bad++; $display("FAIL t5_leftover got=%0d want=0", exp_q.size()); end
    en_zoom = 1'b1;
  endtask

  task automatic test_reset_mid_word();
    logic xf, ac, ls, rd, vl; logic [31:0] dt; logic [W-1:0] e;
    int idx = 0, nx = 0;
    sel_zoom_mode = 2'b10;
    for (int c = 0; c < 16; c++) begin
      rst = (c == 3);
      cycle((c == 0) || (c >= 4 && idx < 2), (idx == 0) ? 32'h5A5A_0001 : 32'h6B6B_0002,
            (c != 3), xf, ac, dt, ls, rd, vl);
      if (ac) idx++;
      if (c == 3) exp_q.delete();
      if (c == 4) begin
        total++;
        if (vl !== 1'b0 || rd !== 1'b1 || ls !== 1'b0 || dt !== 32'h0) begin
          bad++; $display("FAIL t6_after_rst got vld=%b rdy=%b last=%b data=%h want 0/1/0/0", vl, rd, ls, dt);
        end
      end
      if (xf) begin
        nx++; total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL t6_extra got=%h want=none", dt); end
        else begin
          e = exp_q.pop_front();
          if ({ls, dt} !== e) begin bad++; $display("FAIL t6_word got=%b/%h want=%b/%h", ls, dt, e[32], e[31:0]); end
        end
      end
    end
    rst = 1'b0;
    total++; if (nx != 10) begin bad++; $display("FAIL t6_count got=%0d want=10", nx); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL t6_leftover got=%0d want=0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_2x_back_to_back();
    test_8x_single();
    test_stall();
    test_mode_change();
    test_bypass();
    test_reset_mid_word();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
